// File: rtl/tlc_pkg.sv
// Purpose : shared types and default timing for the two-way traffic-light controller.
// Contents: FSM state enum (3-bit), lamp-vector struct, default phase lengths,
//           and the Moore lamp decode used by traffic_light_top.
package tlc_pkg;

    // Default phase lengths, in clock cycles.
    localparam int TLC_GREEN_CYC_DEF     = 20;
    localparam int TLC_MIN_GREEN_CYC_DEF = 5;
    localparam int TLC_YELLOW_CYC_DEF    = 4;
    localparam int TLC_ALLRED_CYC_DEF    = 2;
    localparam int TLC_DEBOUNCE_CYC_DEF  = 4;
    localparam int TLC_TMR_W_DEF         = 8;

    // Cyclic order: NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B.
    // Codes 6 and 7 are illegal and recover to NS_GREEN.
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } tlc_state_e;

    // One bit per lamp; exactly one bit per direction is set in every legal state.
    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
    } lamps_t;

    // Moore decode. An illegal code shows all-red for the single cycle it can
    // exist, so the one-lamp-per-direction and no-conflict rules still hold.
    function automatic lamps_t lamp_decode(input tlc_state_e s);
        lamps_t l;
        l = '0;
        case (s)
            NS_GREEN: begin
                l.ns_green = 1'b1;
                l.ew_red   = 1'b1;
            end
            NS_YELLOW: begin
                l.ns_yellow = 1'b1;
                l.ew_red    = 1'b1;
            end
            EW_GREEN: begin
                l.ns_red   = 1'b1;
                l.ew_green = 1'b1;
            end
            EW_YELLOW: begin
                l.ns_red    = 1'b1;
                l.ew_yellow = 1'b1;
            end
            default: begin
                // ALLRED_A, ALLRED_B and illegal codes
                l.ns_red = 1'b1;
                l.ew_red = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_btn_cond.sv
// Purpose : conditions the asynchronous active-low request button and emits a
//           one-cycle pulse on each press (falling edge of the conditioned level).
// Ports   : clk, rst (async, active-high), btn_i (raw, active-low), press_o (pulse).
// Latency : press_o is high in the cycle after the 2nd sync edge, so a register fed
//           by it captures the press on the 3rd edge after btn_i falls. With
//           TLC_DEBOUNCE_EN defined a debounce counter adds DEBOUNCE_CYC edges.
// No backpressure: press_o is a pulse and must be captured by the consumer.
module tlc_btn_cond
`ifdef TLC_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYC = tlc_pkg::TLC_DEBOUNCE_CYC_DEF
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    // Two-flop synchronizer. Both flops reset to 1 (button released) so that
    // leaving reset never looks like a press.
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Level fed to the edge detector.
    logic level;

`ifdef TLC_DEBOUNCE_EN
    // The debounced level follows sync2_q only after sync2_q has disagreed with
    // it for DEBOUNCE_CYC consecutive cycles; any return to agreement restarts
    // the count, so shorter glitches never reach the edge detector.
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;

    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    // Edge register: previous level. A 1->0 step of the level is one press;
    // holding the button low keeps both at 0 and produces nothing further.
    logic level_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_prev_q <= 1'b1;
        end else begin
            level_prev_q <= level;
        end
    end

    assign press_o = level_prev_q & ~level;

endmodule

// File: rtl/traffic_light_top.sv
// Purpose : two-way intersection traffic-light controller (board top level).
//           Timed six-state Moore FSM; a latched crossing request shortens NS
//           green to MIN_GREEN_CYC so EW is served early.
// Ports   : clk, rst (async, active-high), btn (active-low request, async),
//           ns_red/ns_yellow/ns_green, ew_red/ew_yellow/ew_green (lamp drives).
// Latency : lamps decode from the state register only; a press reaches req on the
//           3rd edge after btn falls (+DEBOUNCE_CYC when TLC_DEBOUNCE_EN is defined).
// Optional: macro TLC_DEBOUNCE_EN inserts a debouncer in the button path.
module traffic_light_top
    import tlc_pkg::*;
#(
`ifdef TLC_DEBOUNCE_EN
    parameter int DEBOUNCE_CYC  = TLC_DEBOUNCE_CYC_DEF,
`endif
    parameter int GREEN_CYC     = TLC_GREEN_CYC_DEF,
    parameter int MIN_GREEN_CYC = TLC_MIN_GREEN_CYC_DEF,
    parameter int YELLOW_CYC    = TLC_YELLOW_CYC_DEF,
    parameter int ALLRED_CYC    = TLC_ALLRED_CYC_DEF,
    parameter int TMR_W         = TLC_TMR_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ns_red,
    output logic ns_green,
    output logic ns_yellow,
    output logic ew_red,
    output logic ew_green,
    output logic ew_yellow
);

    // Terminal timer values: a state of length N is left on the edge where the
    // timer shows N-1, which gives exactly N cycles in the state.
    localparam logic [TMR_W-1:0] GREEN_LAST  = TMR_W'(GREEN_CYC - 1);
    localparam logic [TMR_W-1:0] MIN_LAST    = TMR_W'(MIN_GREEN_CYC - 1);
    localparam logic [TMR_W-1:0] YELLOW_LAST = TMR_W'(YELLOW_CYC - 1);
    localparam logic [TMR_W-1:0] ALLRED_LAST = TMR_W'(ALLRED_CYC - 1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic press;

    tlc_btn_cond
`ifdef TLC_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    )
`endif
    u_btn_cond (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn),
        .press_o (press)
    );

    // ------------------------------------------------------------------
    // State, timer and request registers
    // ------------------------------------------------------------------
    tlc_state_e       state_q;
    tlc_state_e       state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             req_q;
    logic             req_d;
    logic             ew_entry;
    lamps_t           lamps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NS_GREEN;
            tmr_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            req_q   <= req_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, timer, request and lamp decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;

        case (state_q)
            NS_GREEN: begin
                // A pending request ends NS green once the minimum has elapsed.
                if ((tmr_q == GREEN_LAST) || (req_q && (tmr_q >= MIN_LAST))) begin
                    state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (tmr_q == YELLOW_LAST) begin
                    state_d = ALLRED_A;
                end
            end
            ALLRED_A: begin
                if (tmr_q == ALLRED_LAST) begin
                    state_d = EW_GREEN;
                end
            end
            EW_GREEN: begin
                if (tmr_q == GREEN_LAST) begin
                    state_d = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (tmr_q == YELLOW_LAST) begin
                    state_d = ALLRED_B;
                end
            end
            ALLRED_B: begin
                if (tmr_q == ALLRED_LAST) begin
                    state_d = NS_GREEN;
                end
            end
            default: begin
                state_d = NS_GREEN;
            end
        endcase

        // Timer restarts on every state change, including illegal-code recovery.
        if (state_d != state_q) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + 1'b1;
        end

        // The request is served by entering EW green. A press arriving on that
        // same edge belongs to the next NS green, so setting beats clearing.
        ew_entry = (state_q == ALLRED_A) && (state_d == EW_GREEN);
        if (press) begin
            req_d = 1'b1;
        end else if (ew_entry) begin
            req_d = 1'b0;
        end else begin
            req_d = req_q;
        end

        lamps = lamp_decode(state_q);
    end

    assign ns_red    = lamps.ns_red;
    assign ns_yellow = lamps.ns_yellow;
    assign ns_green  = lamps.ns_green;
    assign ew_red    = lamps.ew_red;
    assign ew_yellow = lamps.ew_yellow;
    assign ew_green  = lamps.ew_green;

endmodule

// File: tb/tb_traffic_light_top.sv
// Scoreboarded bench for traffic_light_top: the driver pushes the expected lamp
// vector for every cycle it drives; the monitor pops one entry per cycle on the
// falling clock edge and compares it, along with the lamp safety rules.
`timescale 1ns/1ps
module tb_traffic_light_top;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic ns_red, ns_green, ns_yellow, ew_red, ew_green, ew_yellow;

    traffic_light_top dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .ns_red    (ns_red),
        .ns_green  (ns_green),
        .ns_yellow (ns_yellow),
        .ew_red    (ew_red),
        .ew_green  (ew_green),
        .ew_yellow (ew_yellow)
    );

    always #5 clk = ~clk;

    // Edges from btn falling to req set: 2 sync flops + edge register,
    // plus 4 debounce cycles when the debouncer is built.
`ifdef TLC_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    localparam logic [5:0] L_NSG = 6'b001_100;
    localparam logic [5:0] L_NSY = 6'b010_100;
    localparam logic [5:0] L_AR  = 6'b100_100;
    localparam logic [5:0] L_EWG = 6'b100_001;
    localparam logic [5:0] L_EWY = 6'b100_010;

    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;
    logic [5:0] lamps;
    int         total = 0;
    int         bad   = 0;
    int         hold  = 0;

    assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            total++;
            if (lamps !== mon_exp) begin
                bad++;
                $display("FAIL lamps t=%0t got=%b want=%b", $time, lamps, mon_exp);
            end
            total++;
            if (($countones(lamps[5:3]) != 1) || ($countones(lamps[2:0]) != 1) ||
                (ns_green && ew_green) ||
                ((ns_green || ns_yellow) && !ew_red) ||
                ((ew_green || ew_yellow) && !ns_red)) begin
                bad++;
                $display("FAIL safety t=%0t got=%b want=one-hot-per-dir,no-conflict", $time, lamps);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    // Advance to just after the next rising edge; release the button when its
    // hold time runs out.
    task automatic step();
        @(posedge clk);
        #1;
        if (hold > 0) begin
            hold--;
            if (hold == 0) btn = 1'b1;
        end
    endtask

    task automatic run(input logic [5:0] l, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(l);
            step();
        end
    endtask

    // Press at the start of the current cycle, held low for len cycles.
    task automatic press(input int len);
        btn  = 1'b0;
        hold = len;
    endtask

    // Everything after NS green through the end of ALLRED_B.
    task automatic rest_of_cycle();
        run(L_NSY, 4);
        run(L_AR, 2);
        run(L_EWG, 20);
        run(L_EWY, 4);
        run(L_AR, 2);
    endtask

    // NS green length when a press lands at NS cycle p (req visible at p+LAT).
    function automatic int nsg_len(input int p);
        int r;
        r = p + LAT + 1;
        return (r < 5) ? 5 : r;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        btn = 1'b1;
        @(posedge clk);
        #1;
        // Reset held 4 cycles: NS green / EW red throughout.
        run(L_NSG, 4);
        rst = 1'b0;

        // Full undisturbed cycle, 52 cycles.
        run(L_NSG, 20);
        rest_of_cycle();

        // Press at NS cycle 10, held 20 cycles: req at cycle 10+LAT, NS ends early.
        run(L_NSG, 10);
        press(20);
        run(L_NSG, nsg_len(10) - 10);
        rest_of_cycle();
        // req was cleared on EW entry: full-length NS green again.
        run(L_NSG, 20);
        rest_of_cycle();

        // Press at NS cycle 0: NS green stops at the minimum; next NS green is full.
        press(10);
        run(L_NSG, nsg_len(0));
        rest_of_cycle();
        run(L_NSG, 20);
        run(L_NSY, 4);
        run(L_AR, 2);

        // Press during EW green stays pending and shortens the next NS green.
        run(L_EWG, 5);
        press(10);
        run(L_EWG, 15);
        run(L_EWY, 4);
        run(L_AR, 2);
        run(L_NSG, 5);
        run(L_NSY, 4);
        run(L_AR, 2);

        // Pending press, then reset mid EW yellow: lamps revert before the next
        // clock edge, and the pending req is discarded.
        run(L_EWG, 3);
        press(10);
        run(L_EWG, 17);
        run(L_EWY, 2);
        rst = 1'b1;
        run(L_NSG, 3);
        rst = 1'b0;
        run(L_NSG, 20);
        rest_of_cycle();

        // 2-cycle glitch: a press without the debouncer, ignored with it.
        press(2);
        run(L_NSG, (LAT == 3) ? 5 : 20);
        rest_of_cycle();

        // 10-cycle press at NS cycle 0 (req after LAT edges).
        press(10);
        run(L_NSG, nsg_len(0));
        rest_of_cycle();

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
